// File: rtl/traffic_sensor_cond.sv
// traffic_sensor_cond
//   Vehicle-presence conditioner that drives the t[1:0] input of trafficlight.
//   Each road synchronises its raw loop-sensor bit through two flops. It then
//   debounces the bit (DEBOUNCE_TICKS ticks of presence) and stretches presence
//   (HOLD_TICKS ticks of absence) before it reports a clean occupancy flag.
//   Lane index 1 is road A and lane index 0 is road B. The lanes never interact.
//
// Ports
//   clk        in   rising-edge system clock
//   reset      in   asynchronous active-low reset
//   tick       in   1-cycle timebase strobe; all debounce and hold timing counts ticks
//   sensor_raw in   [1]=road A, [0]=road B, raw asynchronous sensors
//   t          out  registered occupancy flags, [1]=A, [0]=B
//   cnt_clr    in   synchronous clear of both arrival counters   (CAR_COUNT_EN)
//   car_cnt_a  out  saturating road A arrival count              (CAR_COUNT_EN)
//   car_cnt_b  out  saturating road B arrival count              (CAR_COUNT_EN)
//
// Optional feature: define CAR_COUNT_EN to add the arrival counters and their ports.

module traffic_sensor_lane #(
  parameter int DEBOUNCE_TICKS = 4,
  parameter int HOLD_TICKS     = 8,
  parameter int TW             = 4,
  parameter int CNT_W          = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tick_i,
  input  logic             s_i,
`ifdef CAR_COUNT_EN
  input  logic             cnt_clr_i,
  output logic [CNT_W-1:0] cnt_o,
`endif
  output logic             t_o
);

  typedef enum logic [1:0] {IDLE, QUAL, OCC, HOLD} lane_st_e;

  lane_st_e        state_q;
  logic [TW-1:0]   timer_q;
  logic            t_q;

  // t_q is updated on the same edge that enters OCC or IDLE. The controller
  // therefore sees a flop output, and no decode glitches reach it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      timer_q <= '0;
      t_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (s_i) begin
          state_q <= QUAL;
          timer_q <= '0;
        end
        // A drop of s has priority over a tick in the same cycle.
        QUAL: if (!s_i) state_q <= IDLE;
              else if (tick_i) begin
                if (timer_q == TW'(DEBOUNCE_TICKS - 1)) begin
                  state_q <= OCC;
                  t_q     <= 1'b1;
                end else timer_q <= timer_q + 1'b1;
              end
        OCC:  if (!s_i) begin
          state_q <= HOLD;
          timer_q <= '0;
        end
        // Presence returning abandons the hold. OCC->HOLD restarts the timer.
        HOLD: if (s_i) state_q <= OCC;
              else if (tick_i) begin
                if (timer_q == TW'(HOLD_TICKS - 1)) begin
                  state_q <= IDLE;
                  t_q     <= 1'b0;
                end else timer_q <= timer_q + 1'b1;
              end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign t_o = t_q;

`ifdef CAR_COUNT_EN
  logic             arrive;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Fires on the cycle whose edge takes the lane from QUAL to OCC (t rising).
  assign arrive = (state_q == QUAL) && s_i && tick_i &&
                  (timer_q == TW'(DEBOUNCE_TICKS - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i)                   cnt_d = '0;
    else if (arrive && cnt_q != '1)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
`endif

endmodule

module traffic_sensor_cond #(
  parameter int DEBOUNCE_TICKS = 4,
  parameter int HOLD_TICKS     = 8,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [1:0]       sensor_raw,
  output logic [1:0]       t
`ifdef CAR_COUNT_EN
  ,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] car_cnt_a,
  output logic [CNT_W-1:0] car_cnt_b
`endif
);

  localparam int NUM_LANES = 2;
  localparam int MAX_T     = (DEBOUNCE_TICKS > HOLD_TICKS) ? DEBOUNCE_TICKS : HOLD_TICKS;
  localparam int TW        = $clog2(MAX_T) + 1;

  // Two-stage synchroniser as a shift register. Stage [1] is the clean s.
  logic [1:0][NUM_LANES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= {sync_q[0], sensor_raw};
  end

`ifdef CAR_COUNT_EN
  logic [NUM_LANES-1:0][CNT_W-1:0] cnt;
  assign car_cnt_a = cnt[1];
  assign car_cnt_b = cnt[0];
`endif

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    traffic_sensor_lane #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .HOLD_TICKS    (HOLD_TICKS),
      .TW            (TW),
      .CNT_W         (CNT_W)
    ) u_lane (
      .clk_i    (clk),
      .rst_ni   (reset),
      .tick_i   (tick),
      .s_i      (sync_q[1][i]),
`ifdef CAR_COUNT_EN
      .cnt_clr_i(cnt_clr),
      .cnt_o    (cnt[i]),
`endif
      .t_o      (t[i])
    );
  end

endmodule

// File: tb/tb_traffic_sensor_cond.sv
module tb_traffic_sensor_cond;

  localparam int DB = 4;
  localparam int HD = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          tick;
  logic [1:0]    sensor_raw;
  logic [1:0]    t;
  logic          cnt_clr;
`ifdef CAR_COUNT_EN
  logic [CW-1:0] car_cnt_a, car_cnt_b;
`endif

  always #5 clk = ~clk;

  traffic_sensor_cond #(.DEBOUNCE_TICKS(DB), .HOLD_TICKS(HD), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .sensor_raw(sensor_raw),
`ifdef CAR_COUNT_EN
    .cnt_clr   (cnt_clr),
    .car_cnt_a (car_cnt_a),
    .car_cnt_b (car_cnt_b),
`endif
    .t         (t)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // The reference model uses run lengths. A presence run counts the ticks seen
  // while s has been 1 for at least one earlier cycle, and an absence run
  // counts the same for s == 0. Occupancy turns on when the presence run
  // reaches DB and turns off when the absence run reaches HD.
  bit [1:0] m_s1, m_s2, m_prev;
  bit       occ  [2];
  int       pres [2];
  int       absr [2];
  int       cnt  [2];
  int       cyc = 0;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_prev = '0;
    for (int i = 0; i < 2; i++) begin
      occ[i] = 0; pres[i] = 0; absr[i] = 0; cnt[i] = 0;
    end
  endtask

  function automatic bit pred_arrive(input int i, input bit tk);
    return !occ[i] && m_s2[i] && m_prev[i] && tk && (pres[i] == DB - 1);
  endfunction

  task automatic model_edge(input bit tk, input bit clr, input logic [1:0] raw);
    for (int i = 0; i < 2; i++) begin
      bit s, arr;
      s   = m_s2[i];
      arr = 0;
      if (!s) pres[i] = 0; else if (m_prev[i] && tk) pres[i]++;
      if (s) absr[i] = 0;  else if (!m_prev[i] && tk) absr[i]++;
      if (!occ[i] && pres[i] == DB) begin occ[i] = 1; arr = 1; end
      else if (occ[i] && absr[i] == HD) occ[i] = 0;
      if (clr) cnt[i] = 0;
      else if (arr && cnt[i] < (1 << CW) - 1) cnt[i]++;
      m_prev[i] = s;
    end
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  // Runs one clock cycle. Inputs are driven at the negedge, the model is
  // updated at the posedge, and the DUT is checked 1 time unit later.
  task automatic step(input logic [1:0] raw, input bit tk, input bit clr, input bit rst);
    @(negedge clk);
    sensor_raw = raw; tick = tk; cnt_clr = clr; reset = rst;
    @(posedge clk);
    if (!rst) model_reset();
    else      model_edge(tk, clr, raw);
    #1;
    chk("t", 32'(t), 32'({occ[1], occ[0]}));
`ifdef CAR_COUNT_EN
    chk("car_cnt_a", 32'(car_cnt_a), 32'(cnt[1]));
    chk("car_cnt_b", 32'(car_cnt_b), 32'(cnt[0]));
`endif
    cyc++;
  endtask

  // mode 0: tick on every 4th clk, mode 1: tick held high, mode 2: random ticks
  function automatic bit gen_tick(input int mode);
    case (mode)
      0:       return (cyc % 4) == 0;
      1:       return 1'b1;
      default: return $urandom_range(0, 2) == 0;
    endcase
  endfunction

  task automatic run(input logic [1:0] raw, input int n, input int mode);
    for (int k = 0; k < n; k++) step(raw, gen_tick(mode), 1'b0, 1'b1);
  endtask

  initial begin
    sensor_raw = 2'b00; tick = 1'b0; cnt_clr = 1'b0; reset = 1'b0;
    model_reset();

    // 1: reset held low with both sensors present
    #2;
    chk("reset_t", 32'(t), 32'd0);
    for (int k = 0; k < 6; k++) step(2'b11, gen_tick(0), 1'b0, 1'b0);
    run(2'b11, 40, 0);
    run(2'b00, 50, 0);

    // 2: glitch shorter than the debounce window on road A
    run(2'b10, 12, 0);
    run(2'b00, 10, 0);
    chk("glitch_t1", 32'(t[1]), 32'd0);

    // 3: assert on road A only
    run(2'b10, 30, 0);
    chk("assert_t", 32'(t), 32'b10);

    // 4: gap shorter than hold, then a gap long enough to release
    run(2'b00, 20, 0);
    chk("short_gap_t1", 32'(t[1]), 32'd1);
    run(2'b10, 8, 0);
    run(2'b00, 40, 0);
    chk("long_gap_t1", 32'(t[1]), 32'd0);

    // boundary: tick held high counts clk cycles
    run(2'b01, 9, 1);
    run(2'b00, 12, 1);

    // 5: async reset while both lanes are in HOLD
    run(2'b11, 30, 0);
    chk("pre_rst_t", 32'(t), 32'b11);
    run(2'b00, 6, 0);
    #3 reset = 1'b0;
    #1 chk("async_rst_t", 32'(t), 32'd0);
    model_reset();
    step(2'b11, 1'b0, 1'b0, 1'b0);
    step(2'b11, 1'b0, 1'b0, 1'b0);
    run(2'b11, 30, 0);

`ifdef CAR_COUNT_EN
    // 6: saturation and clear-wins-over-arrival on road B
    step(2'b00, 1'b0, 1'b1, 1'b1);
    run(2'b00, 40, 0);
    for (int a = 0; a < 5; a++) begin
      run(2'b01, 24, 0);
      run(2'b00, 40, 0);
    end
    chk("sat_cnt_b", 32'(car_cnt_b), 32'd3);
    begin
      bit seen = 0;
      for (int k = 0; k < 60 && !seen; k++) begin
        bit tk, pa;
        tk = gen_tick(0);
        pa = pred_arrive(0, tk);
        step(2'b01, tk, pa, 1'b1);
        if (pa) seen = 1;
      end
      chk("clr_arrival_seen", 32'(seen), 32'd1);
      chk("clr_cnt_b", 32'(car_cnt_b), 32'd0);
    end
    run(2'b00, 40, 0);
`endif

    // random segments with random tick modes and occasional clears
    for (int seg = 0; seg < 60; seg++) begin
      logic [1:0] raw;
      int n, mode;
      raw  = 2'($urandom_range(0, 3));
      n    = $urandom_range(1, 40);
      mode = $urandom_range(0, 2);
      for (int k = 0; k < n; k++)
        step(raw, gen_tick(mode), ($urandom_range(0, 30) == 0), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
